// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// Registered, lane-parallel half adder. Each of WIDTH independent bit lanes
// produces sum = a ^ b and c_out = a & b, captured on the rising clock edge
// together with a valid flag. Summary outputs report whether any lane
// carried and how many lanes carried.
//
// Parameters:
//   WIDTH  number of independent bit lanes (1..64)
//   CNT_W  width of the statistics counters (optional feature only)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (priority over in_valid)
//   in_valid       qualifies a and b this cycle
//   a, b           operands, one bit per lane
//   out_valid      sum/c_out hold a fresh result
//   sum            per-lane a ^ b, registered
//   c_out          per-lane a & b, registered
//   carry_any      OR of all c_out bits, registered
//   carry_cnt      number of set c_out bits, registered
//   txn_cnt        (HALF_ADDER_STATS_EN) saturating accepted-input count
//   carry_evt_cnt  (HALF_ADDER_STATS_EN) saturating count of carrying inputs
//
// Optional feature macro: HALF_ADDER_STATS_EN
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           sum,
  output logic [WIDTH-1:0]           c_out,
  output logic                       carry_any,
  output logic [$clog2(WIDTH+1)-1:0] carry_cnt
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0]           txn_cnt,
  output logic [CNT_W-1:0]           carry_evt_cnt
`endif
);

  localparam int CC_W = $clog2(WIDTH + 1);

  // Reject out-of-range configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_param_check
    $error("half_adder: WIDTH must be 1..64 and CNT_W >= 1");
  end

  // Count the set bits of a lane vector.
  function automatic logic [CC_W-1:0] popcount(input logic [WIDTH-1:0] vec);
    logic [CC_W-1:0] acc;
    acc = {CC_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + CC_W'(vec[i]);
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] carry_s;
  logic             carry_any_s;
  logic [CC_W-1:0]  carry_cnt_s;

  // Per-lane half-add and carry summary; lanes never interact.
  always_comb begin
    sum_s       = a ^ b;
    carry_s     = a & b;
    carry_any_s = |carry_s;
    carry_cnt_s = popcount(carry_s);
  end

  // Result registers: data only loads on accepted inputs, so idle cycles
  // (including X operands while in_valid=0) leave the last result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      c_out     <= {WIDTH{1'b0}};
      carry_any <= 1'b0;
      carry_cnt <= {CC_W{1'b0}};
    end else if (in_valid) begin
      out_valid <= 1'b1;
      sum       <= sum_s;
      c_out     <= carry_s;
      carry_any <= carry_any_s;
      carry_cnt <= carry_cnt_s;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating statistics counters; they stick at all-ones until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt       <= {CNT_W{1'b0}};
      carry_evt_cnt <= {CNT_W{1'b0}};
    end else if (in_valid) begin
      if (txn_cnt != CNT_MAX) begin
        txn_cnt <= txn_cnt + CNT_W'(1'b1);
      end else begin
        txn_cnt <= txn_cnt;
      end
      if (carry_any_s && (carry_evt_cnt != CNT_MAX)) begin
        carry_evt_cnt <= carry_evt_cnt + CNT_W'(1'b1);
      end else begin
        carry_evt_cnt <= carry_evt_cnt;
      end
    end else begin
      txn_cnt       <= txn_cnt;
      carry_evt_cnt <= carry_evt_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//
// Drives an 8-lane instance (CNT_W=2) and a 1-lane instance from one clock
// and reset, and compares every output each cycle against a behavioural
// model that treats each lane as a two-input integer addition.
// -----------------------------------------------------------------------------
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid8, in_valid1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;

  logic       out_valid8, out_valid1;
  logic [7:0] sum8, c_out8;
  logic [0:0] sum1, c_out1;
  logic       carry_any8, carry_any1;
  logic [3:0] carry_cnt8;
  logic [0:0] carry_cnt1;
`ifdef HALF_ADDER_STATS_EN
  logic [1:0]  txn_cnt8, carry_evt_cnt8;
  logic [15:0] txn_cnt1, carry_evt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // model state, 8-lane
  int m_v8, m_sum8, m_cout8, m_any8, m_cnt8, m_txn8, m_evt8;
  // model state, 1-lane
  int m_v1, m_sum1, m_cout1, m_any1, m_cnt1, m_txn1, m_evt1;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8),
    .out_valid(out_valid8), .sum(sum8), .c_out(c_out8),
    .carry_any(carry_any8), .carry_cnt(carry_cnt8)
`ifdef HALF_ADDER_STATS_EN
    , .txn_cnt(txn_cnt8), .carry_evt_cnt(carry_evt_cnt8)
`endif
  );

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1),
    .out_valid(out_valid1), .sum(sum1), .c_out(c_out1),
    .carry_any(carry_any1), .carry_cnt(carry_cnt1)
`ifdef HALF_ADDER_STATS_EN
    , .txn_cnt(txn_cnt1), .carry_evt_cnt(carry_evt_cnt1)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model of one lane group: each lane is an integer a+b split into
  // low bit (sum) and high bit (carry).
  task automatic model(input int r, input int v, input int av, input int bv,
                       input int lanes, input int cmax,
                       inout int mv, inout int ms, inout int mc,
                       inout int many, inout int mcnt, inout int mtxn, inout int mevt);
    int s, c, n;
    if (r != 0) begin
      mv = 0; ms = 0; mc = 0; many = 0; mcnt = 0; mtxn = 0; mevt = 0;
    end else if (v != 0) begin
      s = 0; c = 0; n = 0;
      for (int i = 0; i < lanes; i++) begin
        int t;
        t = ((av >> i) & 1) + ((bv >> i) & 1);
        s += (t % 2) << i;
        c += (t / 2) << i;
        n += t / 2;
      end
      mv = 1; ms = s; mc = c; mcnt = n; many = (n > 0) ? 1 : 0;
      mtxn = (mtxn < cmax) ? mtxn + 1 : cmax;
      if (n > 0) mevt = (mevt < cmax) ? mevt + 1 : cmax;
    end else begin
      mv = 0;
    end
  endtask

  // One clock: apply inputs, advance model, compare after the edge.
  task automatic tick(input logic r, input logic v8, input logic [7:0] av8,
                      input logic [7:0] bv8, input logic v1, input logic av1,
                      input logic bv1);
    rst = r; in_valid8 = v8; a8 = av8; b8 = bv8;
    in_valid1 = v1; a1 = av1; b1 = bv1;
    @(posedge clk);
    #1;
    model(int'(r), int'(v8), int'(av8), int'(bv8), 8, 3,
          m_v8, m_sum8, m_cout8, m_any8, m_cnt8, m_txn8, m_evt8);
    model(int'(r), int'(v1), int'(av1), int'(bv1), 1, 65535,
          m_v1, m_sum1, m_cout1, m_any1, m_cnt1, m_txn1, m_evt1);
    check("valid8", out_valid8, m_v8);
    check("sum8",   sum8,       m_sum8);
    check("cout8",  c_out8,     m_cout8);
    check("any8",   carry_any8, m_any8);
    check("cnt8",   carry_cnt8, m_cnt8);
    check("valid1", out_valid1, m_v1);
    check("sum1",   sum1,       m_sum1);
    check("cout1",  c_out1,     m_cout1);
    check("any1",   carry_any1, m_any1);
    check("cnt1",   carry_cnt1, m_cnt1);
`ifdef HALF_ADDER_STATS_EN
    check("txn8", txn_cnt8,       m_txn8);
    check("evt8", carry_evt_cnt8, m_evt8);
    check("txn1", txn_cnt1,       m_txn1);
    check("evt1", carry_evt_cnt1, m_evt1);
`endif
  endtask

  initial begin
    m_v8 = 0; m_sum8 = 0; m_cout8 = 0; m_any8 = 0; m_cnt8 = 0; m_txn8 = 0; m_evt8 = 0;
    m_v1 = 0; m_sum1 = 0; m_cout1 = 0; m_any1 = 0; m_cnt1 = 0; m_txn1 = 0; m_evt1 = 0;
    rst = 1'b1; in_valid8 = 1'b0; in_valid1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;

    // reset held with valid all-ones operands
    tick(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("rst_valid8", out_valid8, 0);
    check("rst_cnt8",   carry_cnt8, 0);

    // 1-lane sweep {b,a}=0..3 alongside the 8-lane patterns
    tick(1'b0, 1'b1, 8'hF0, 8'hCC, 1'b1, 1'b0, 1'b0);
    check("dir_sum8", sum8, 8'h3C);
    check("dir_cout8", c_out8, 8'hC0);
    check("dir_cnt8", carry_cnt8, 2);
    check("sweep0", {c_out1, sum1}, 2'b00);
    tick(1'b0, 1'b1, 8'h0F, 8'h30, 1'b1, 1'b1, 1'b0);
    check("dir2_sum8", sum8, 8'h3F);
    check("dir2_any8", carry_any8, 0);
    check("sweep1", {c_out1, sum1}, 2'b01);
    tick(1'b0, 1'b0, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b1);
    check("sweep2", {c_out1, sum1}, 2'b01);
    check("hold_sum8", sum8, 8'h3F);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    check("sweep3", {c_out1, sum1}, 2'b10);

    // hold: valid a=1,b=0 then idle with a=b=1
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    check("hold_sum1", sum1, 1);
    check("hold_cout1", c_out1, 0);
    check("hold_valid1", out_valid1, 0);

    // mid-stream reset on an all-carry stream
    tick(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("mid_rst_cout8", c_out8, 8'h00);
    tick(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    check("mid_cout8", c_out8, 8'hFF);
    check("mid_cnt8", carry_cnt8, 8);

    // saturation: four more carrying inputs (five since reset)
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'h81, 8'h01, 1'b0, 1'b0, 1'b0);
`ifdef HALF_ADDER_STATS_EN
    check("sat_txn8", txn_cnt8, 3);
    check("sat_evt8", carry_evt_cnt8, 3);
    tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("sat_rst_txn8", txn_cnt8, 0);
`endif

    // randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
